// File: rtl/wash_pkg.sv
// Shared washer-side definitions: payment controller states, default prices
// and the washer's own state encoding.
package wash_pkg;

  localparam int unsigned CREDIT_W         = 3;
  localparam int unsigned DEF_PRICE_SINGLE = 2;
  localparam int unsigned DEF_PRICE_DOUBLE = 3;
  localparam int unsigned DEF_MAX_CREDIT   = 7;
  localparam int unsigned DEF_START_HOLD   = 16;
  localparam int unsigned DEF_TIMEOUT      = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_REFUND = 3'd4
  } pay_state_t;

  typedef enum logic [1:0] {
    WSH_IDLE = 2'd0,
    WSH_FILL = 2'd1,
    WSH_WASH = 2'd2,
    WSH_SPIN = 2'd3
  } washer_state_t;

  // Price of the selected programme, sized to the credit counter.
  function automatic logic [CREDIT_W-1:0] price_of(input logic dbl,
                                                   input int unsigned p_single,
                                                   input int unsigned p_double);
    return dbl ? CREDIT_W'(p_double) : CREDIT_W'(p_single);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector against a registered copy of the input level.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/wash_payment_ctrl.sv
// Coin-operated wash payment controller: counts credit, starts single/double
// washes, rejects surplus coins and refunds pending credit on cancel/timeout.
module wash_payment_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned PRICE_SINGLE = DEF_PRICE_SINGLE,
  parameter int unsigned PRICE_DOUBLE = DEF_PRICE_DOUBLE,
  parameter int unsigned MAX_CREDIT   = DEF_MAX_CREDIT,
  parameter int unsigned START_HOLD   = DEF_START_HOLD,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_pulse,
  input  logic       sel_double,
  input  logic       start_btn,
  input  logic       cancel,
  input  logic       wash_done,
  output logic       coin_in,
  output logic       double_wash,
  output logic [2:0] credit,
  output logic       refund_pulse,
  output logic       reject_pulse,
  output logic       busy
);

  localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  pay_state_t            state_q, state_n;
  logic [CREDIT_W-1:0]   credit_n;
  logic [CREDIT_W-1:0]   price;
  logic [HOLD_W-1:0]     hold_q, hold_n;
  logic [IDLE_W-1:0]     idle_q, idle_n;
  logic                  phase_q, phase_n;
  logic                  coin_in_n, double_n, busy_n, refund_n, reject_n;
  logic                  coin_ok;
  logic                  done_rise_c;

  edge_detect u_done_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (wash_done),
    .rise_c (done_rise_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      credit       <= '0;
      hold_q       <= '0;
      idle_q       <= '0;
      phase_q      <= 1'b0;
      coin_in      <= 1'b0;
      double_wash  <= 1'b0;
      busy         <= 1'b0;
      refund_pulse <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      state_q      <= state_n;
      credit       <= credit_n;
      hold_q       <= hold_n;
      idle_q       <= idle_n;
      phase_q      <= phase_n;
      coin_in      <= coin_in_n;
      double_wash  <= double_n;
      busy         <= busy_n;
      refund_pulse <= refund_n;
      reject_pulse <= reject_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    credit_n  = credit;
    hold_n    = '0;
    idle_n    = '0;
    phase_n   = 1'b0;
    double_n  = double_wash;
    refund_n  = 1'b0;
    reject_n  = 1'b0;
    coin_in_n = 1'b0;
    busy_n    = 1'b0;
    price     = price_of(sel_double, PRICE_SINGLE, PRICE_DOUBLE);
    coin_ok   = coin_pulse && (credit != CREDIT_W'(MAX_CREDIT));

    case (state_q)
      ST_IDLE: begin
        if (coin_pulse) begin
          credit_n = credit + CREDIT_W'(1);
          state_n  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        idle_n = idle_q + IDLE_W'(1);
        if (coin_ok)                   credit_n = credit + CREDIT_W'(1);
        else if (coin_pulse)           reject_n = 1'b1;
        if (coin_pulse || start_btn)   idle_n   = '0;
        // Start test uses the pre-coin credit; an accepted coin is still added.
        if (cancel) begin
          state_n = ST_REFUND;
        end else if (start_btn && (credit >= price)) begin
          credit_n = credit_n - price;
          double_n = sel_double;
          state_n  = ST_START;
        end else if (!coin_pulse && !start_btn &&
                     (idle_q == IDLE_W'(TIMEOUT - 1))) begin
          state_n = ST_REFUND;
        end
      end
      ST_START: begin
        hold_n = hold_q + HOLD_W'(1);
        if (coin_pulse) reject_n = 1'b1;
        if (hold_q == HOLD_W'(START_HOLD - 1)) begin
          hold_n  = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (coin_pulse) reject_n = 1'b1;
        if (done_rise_c) begin
          double_n = 1'b0;
          state_n  = (credit != '0) ? ST_CREDIT : ST_IDLE;
        end
      end
      ST_REFUND: begin
        if (coin_pulse) reject_n = 1'b1;
        // Eject one coin every other cycle until credit is exhausted.
        if (credit == '0) begin
          state_n = ST_IDLE;
        end else if (!phase_q) begin
          refund_n = 1'b1;
          credit_n = credit - CREDIT_W'(1);
          phase_n  = 1'b1;
          if (credit == CREDIT_W'(1)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    coin_in_n = (state_n == ST_START);
    busy_n    = (state_n == ST_START) || (state_n == ST_RUN);
    if (!busy_n) double_n = 1'b0;
  end

endmodule
